// File: rtl/osd_cmd_tx_pkg.sv
// rtl/osd_cmd_tx_pkg.sv - shared types and constants for the OSD command transmitter
//
// Purpose: op codes, OSD command-word constants, FSM state enum and the
//          header-word builder used by osd_cmd_tx.
package osd_tx_pkg;

    typedef enum logic [1:0] {
        OP_DISABLE     = 2'd0,
        OP_ENABLE      = 2'd1,
        OP_ENABLE_INFO = 2'd2,
        OP_WRITE       = 2'd3
    } op_e;

    localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
    localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
    localparam int         EN_BIT         = 0;
    localparam int         INFO_BIT       = 2;
    localparam int         NOMENU_BIT     = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_STRB  = 3'd2,
        ST_GAP   = 3'd3,
        ST_TAIL  = 3'd4
    } state_e;

    // First word of every transaction. Disable is the bare enable-class
    // command with the enable bit clear.
    function automatic logic [15:0] header_word(input op_e op, input logic [4:0] arg);
        logic [7:0] w;
        w = OSD_CMD_ENABLE;
        case (op)
            OP_DISABLE: w = OSD_CMD_ENABLE;
            OP_ENABLE: begin
                w[EN_BIT]     = 1'b1;
                w[NOMENU_BIT] = arg[0];
            end
            OP_ENABLE_INFO: begin
                w[EN_BIT]   = 1'b1;
                w[INFO_BIT] = 1'b1;
            end
            OP_WRITE: w = OSD_CMD_WRITE | {3'b000, arg};
            default: w = OSD_CMD_ENABLE;
        endcase
        return {8'h00, w};
    endfunction

endpackage

// File: rtl/osd_cmd_tx_if.sv
// rtl/osd_cmd_tx_if.sv - command request interface for the OSD command transmitter
//
// Purpose: bundles the command handshake and its sampled arguments.
// Signals: cmd_valid/cmd_ready handshake, cmd_op, cmd_arg, info_x/y (12b),
//          info_w/h (6b), info_rot (2b), wr_len (13b).
// Modports: master drives the request, slave (the transmitter) returns cmd_ready.
interface osd_cmd_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_arg;
    logic [11:0] info_x;
    logic [11:0] info_y;
    logic [5:0]  info_w;
    logic [5:0]  info_h;
    logic [1:0]  info_rot;
    logic [12:0] wr_len;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, info_x, info_y, info_w, info_h, info_rot, wr_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, info_x, info_y, info_w, info_h, info_rot, wr_len,
        output cmd_ready
    );
endinterface

// File: rtl/osd_cmd_tx_pacer.sv
// rtl/osd_cmd_tx_pacer.sv - phase length down-counter for STRB/GAP/TAIL
//
// Purpose: loads the length of the phase being entered and counts it down.
// Ports: clk_sys, reset_n (async active-low); load + load_phase select the
//        phase about to start; last_cycle is high in the final cycle of it.
module osd_tx_pacer
    import osd_tx_pkg::*;
#(
    parameter int STROBE_LEN = 2,
    parameter int GAP_LEN    = 2,
    parameter int FRAME_GAP  = 4
) (
    input  logic   clk_sys,
    input  logic   reset_n,
    input  logic   load,
    input  state_e load_phase,
    output logic   last_cycle
);

    localparam logic [15:0] STRB_M1 = 16'(STROBE_LEN - 1);
    localparam logic [15:0] GAP_M1  = 16'(GAP_LEN - 1);
    localparam logic [15:0] TAIL_M1 = 16'(FRAME_GAP - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] len_m1;

    always_comb begin
        len_m1 = 16'd0;
        case (load_phase)
            ST_STRB: len_m1 = STRB_M1;
            ST_GAP:  len_m1 = GAP_M1;
            ST_TAIL: len_m1 = TAIL_M1;
            default: len_m1 = 16'd0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = len_m1;
        end else if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_cycle = (count_q == 16'd0);

endmodule

// File: rtl/osd_cmd_tx.sv
// rtl/osd_cmd_tx.sv - OSD side-channel command-stream transmitter
//
// Purpose: frames disable/enable/info/write transactions onto io_osd,
//          io_strobe and io_din, fetching write payload from a byte memory.
// Ports: clk_sys, reset_n (async active-low); cmd (osd_cmd_tx_if.slave);
//        rd_addr/rd_data payload memory (1-cycle latency); io_osd, io_strobe,
//        io_din OSD bus; busy while a transaction is in flight.
module osd_cmd_tx
    import osd_tx_pkg::*;
#(
    parameter int STROBE_LEN = 2,
    parameter int GAP_LEN    = 2,
    parameter int FRAME_GAP  = 4
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    osd_cmd_tx_if.slave  cmd,
    output logic [12:0]  rd_addr,
    input  logic [7:0]   rd_data,
    output logic         io_osd,
    output logic         io_strobe,
    output logic [15:0]  io_din,
    output logic         busy
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [12:0] base_q, base_d;
    logic [13:0] n_words_q, n_words_d;
    logic [13:0] word_idx_q, word_idx_d;
    logic [11:0] info_x_q, info_x_d;
    logic [11:0] info_y_q, info_y_d;
    logic [5:0]  info_w_q, info_w_d;
    logic [5:0]  info_h_q, info_h_d;
    logic [1:0]  info_rot_q, info_rot_d;
    logic [15:0] din_q, din_d;
    logic [12:0] rd_addr_q, rd_addr_d;

    logic        pacer_load;
    state_e      pacer_phase;
    logic        last_cycle;
    logic [13:0] next_idx;
    logic        last_word;
    logic [15:0] next_word;

    osd_tx_pacer #(
        .STROBE_LEN (STROBE_LEN),
        .GAP_LEN    (GAP_LEN),
        .FRAME_GAP  (FRAME_GAP)
    ) u_pacer (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .load       (pacer_load),
        .load_phase (pacer_phase),
        .last_cycle (last_cycle)
    );

    assign next_idx  = word_idx_q + 14'd1;
    assign last_word = (word_idx_q == n_words_q - 14'd1);

    // Word that follows the current one; only meaningful when !last_word.
    // For writes rd_data answers the address presented during this STRB.
    always_comb begin
        next_word = din_q;
        case (op_q)
            OP_ENABLE_INFO: begin
                case (next_idx[2:0])
                    3'd1:    next_word = {4'h0, info_x_q};
                    3'd2:    next_word = {4'h0, info_y_q};
                    3'd3:    next_word = {10'h000, info_w_q};
                    3'd4:    next_word = {10'h000, info_h_q};
                    3'd5:    next_word = {14'h0000, info_rot_q};
                    default: next_word = 16'h0000;
                endcase
            end
            OP_WRITE: next_word = {8'h00, rd_data};
            default:  next_word = din_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        base_d      = base_q;
        n_words_d   = n_words_q;
        word_idx_d  = word_idx_q;
        info_x_d    = info_x_q;
        info_y_d    = info_y_q;
        info_w_d    = info_w_q;
        info_h_d    = info_h_q;
        info_rot_d  = info_rot_q;
        din_d       = din_q;
        rd_addr_d   = rd_addr_q;
        pacer_load  = 1'b0;
        pacer_phase = ST_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d       = op_e'(cmd.cmd_op);
                    base_d     = {cmd.cmd_arg, 8'h00};
                    info_x_d   = cmd.info_x;
                    info_y_d   = cmd.info_y;
                    info_w_d   = cmd.info_w;
                    info_h_d   = cmd.info_h;
                    info_rot_d = cmd.info_rot;
                    din_d      = header_word(op_e'(cmd.cmd_op), cmd.cmd_arg);
                    case (op_e'(cmd.cmd_op))
                        OP_ENABLE_INFO: n_words_d = 14'd6;
                        OP_WRITE:       n_words_d = {1'b0, cmd.wr_len} + 14'd1;
                        default:        n_words_d = 14'd1;
                    endcase
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                word_idx_d  = 14'd0;
                if (op_q == OP_WRITE) begin
                    rd_addr_d = base_q;
                end
                pacer_load  = 1'b1;
                pacer_phase = ST_STRB;
                state_d     = ST_STRB;
            end
            ST_STRB: begin
                if (last_cycle) begin
                    if (!last_word) begin
                        din_d = next_word;
                    end
                    pacer_load  = 1'b1;
                    pacer_phase = ST_GAP;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (last_cycle) begin
                    pacer_load = 1'b1;
                    if (last_word) begin
                        din_d       = 16'h0000;
                        rd_addr_d   = 13'd0;
                        pacer_phase = ST_TAIL;
                        state_d     = ST_TAIL;
                    end else begin
                        word_idx_d  = next_idx;
                        // 13-bit add wraps past 0x1FFF to 0 on its own.
                        if (op_q == OP_WRITE) begin
                            rd_addr_d = base_q + next_idx[12:0];
                        end
                        pacer_phase = ST_STRB;
                        state_d     = ST_STRB;
                    end
                end
            end
            ST_TAIL: begin
                if (last_cycle) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_DISABLE;
            base_q     <= 13'd0;
            n_words_q  <= 14'd1;
            word_idx_q <= 14'd0;
            info_x_q   <= 12'd0;
            info_y_q   <= 12'd0;
            info_w_q   <= 6'd0;
            info_h_q   <= 6'd0;
            info_rot_q <= 2'd0;
            din_q      <= 16'h0000;
            rd_addr_q  <= 13'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            base_q     <= base_d;
            n_words_q  <= n_words_d;
            word_idx_q <= word_idx_d;
            info_x_q   <= info_x_d;
            info_y_q   <= info_y_d;
            info_w_q   <= info_w_d;
            info_h_q   <= info_h_d;
            info_rot_q <= info_rot_d;
            din_q      <= din_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    // Bus controls decode straight from the state flop so an asynchronous
    // reset drops them immediately.
    assign io_osd        = (state_q == ST_SETUP) || (state_q == ST_STRB) || (state_q == ST_GAP);
    assign io_strobe     = (state_q == ST_STRB);
    assign io_din        = din_q;
    assign rd_addr       = rd_addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign cmd.cmd_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_osd_cmd_tx.sv
// tb/tb_osd_cmd_tx.sv - directed scoreboard bench for osd_cmd_tx
module tb_osd_cmd_tx;

    localparam int S = 2;
    localparam int G = 2;
    localparam int F = 4;

    logic        clk;
    logic        reset_n;
    logic [12:0] rd_addr;
    logic [7:0]  rd_data;
    logic        io_osd;
    logic        io_strobe;
    logic [15:0] io_din;
    logic        busy;

    logic [7:0]  mem [0:8191];
    logic [15:0] exp_q[$];
    logic [12:0] addr_q[$];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    osd_cmd_tx_if cmd_if ();

    osd_cmd_tx #(
        .STROBE_LEN (S),
        .GAP_LEN    (G),
        .FRAME_GAP  (F)
    ) dut (
        .clk_sys   (clk),
        .reset_n   (reset_n),
        .cmd       (cmd_if),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .io_osd    (io_osd),
        .io_strobe (io_strobe),
        .io_din    (io_din),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] arg, input logic [12:0] len,
                           input int n_words, input logic [15:0] hdr);
        int          c;
        int          rises;
        int          run;
        logic        ps;
        logic        po;
        bit          done;
        logic [15:0] w;
        logic [15:0] w_at_rise;
        logic [12:0] a;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        cmd_if.wr_len    = len;
        @(posedge clk);
        c = 0; rises = 0; run = 0; ps = 1'b0; po = 1'b0; done = 1'b0; w_at_rise = 16'h0;
        while (!done && c < 20000) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                cmd_if.cmd_valid = 1'b0;
                check("setup_osd", io_osd, 1);
                check("setup_strobe", io_strobe, 0);
                check("setup_din", io_din, hdr);
                check("setup_busy", busy, 1);
            end
            if (io_strobe && !ps) begin
                check("rise_cycle", c, 2 + (S + G) * rises);
                check("word_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("word_din", io_din, w);
                end
                w_at_rise = io_din;
                rises++;
            end
            run = io_strobe ? run + 1 : 0;
            if (run == S) begin
                check("din_hold", io_din, w_at_rise);
                if (op == 2'd3 && (rises - 1) < int'(len)) begin
                    check("addr_pending", addr_q.size() > 0, 1);
                    if (addr_q.size() > 0) begin
                        a = addr_q.pop_front();
                        check("rd_addr", rd_addr, a);
                    end
                end
            end
            if (!io_osd && po) begin
                check("osd_fall", c, 2 + (S + G) * n_words);
                check("tail_din", io_din, 0);
            end
            if (cmd_if.cmd_ready) begin
                check("ready_cycle", c, 2 + (S + G) * n_words + F);
                done = 1'b1;
            end
            ps = io_strobe;
            po = io_osd;
        end
        check("cmd_done", done, 1);
        check("strobe_count", rises, n_words);
        check("busy_end", busy, 0);
        check("words_left", exp_q.size(), 0);
    endtask

    initial begin
        logic [12:0] ad;
        for (int i = 0; i < 8192; i++) begin
            ad = 13'(i);
            mem[i] = ad[7:0] ^ 8'h5A;
        end
        mem[13'h300] = 8'hA1;
        mem[13'h301] = 8'hA2;
        mem[13'h302] = 8'hA3;
        mem[13'h303] = 8'hA4;

        reset_n          = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'd0;
        cmd_if.cmd_arg   = 5'd0;
        cmd_if.info_x    = 12'd0;
        cmd_if.info_y    = 12'd0;
        cmd_if.info_w    = 6'd0;
        cmd_if.info_h    = 6'd0;
        cmd_if.info_rot  = 2'd0;
        cmd_if.wr_len    = 13'd0;
        repeat (3) @(negedge clk);
        check("rst_osd", io_osd, 0);
        check("rst_strobe", io_strobe, 0);
        check("rst_din", io_din, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", cmd_if.cmd_ready, 1);

        // disable
        exp_q.push_back(16'h0040);
        run_cmd(2'd0, 5'd0, 13'd0, 1, 16'h0040);

        // enable with menu suppressed
        exp_q.push_back(16'h0049);
        run_cmd(2'd1, 5'd1, 13'd0, 1, 16'h0049);

        // enable-info
        cmd_if.info_x   = 12'd100;
        cmd_if.info_y   = 12'd40;
        cmd_if.info_w   = 6'd20;
        cmd_if.info_h   = 6'd8;
        cmd_if.info_rot = 2'd1;
        exp_q.push_back(16'h0045);
        exp_q.push_back(16'h0064);
        exp_q.push_back(16'h0028);
        exp_q.push_back(16'h0014);
        exp_q.push_back(16'h0008);
        exp_q.push_back(16'h0001);
        run_cmd(2'd2, 5'd0, 13'd0, 6, 16'h0045);

        // write page 3, four bytes
        exp_q.push_back(16'h0023);
        for (int n = 0; n < 4; n++) begin
            ad = 13'h300 + 13'(n);
            exp_q.push_back({8'h00, mem[ad]});
            addr_q.push_back(ad);
        end
        run_cmd(2'd3, 5'd3, 13'd4, 5, 16'h0023);

        // write page 31, 300 bytes: address wraps at byte 256
        exp_q.push_back(16'h003F);
        for (int n = 0; n < 300; n++) begin
            ad = 13'h1F00 + 13'(n);
            exp_q.push_back({8'h00, mem[ad]});
            addr_q.push_back(ad);
        end
        run_cmd(2'd3, 5'd31, 13'd300, 301, 16'h003F);

        // header-only write
        exp_q.push_back(16'h0025);
        run_cmd(2'd3, 5'd5, 13'd0, 1, 16'h0025);

        // reset at cycle 7 of a 4-byte write
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'd3;
        cmd_if.cmd_arg   = 5'd3;
        cmd_if.wr_len    = 13'd4;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_strobe", io_strobe, 1);
        check("pre_rst_addr", rd_addr, 13'h301);
        #1 reset_n = 1'b0;
        #1;
        check("arst_osd", io_osd, 0);
        check("arst_strobe", io_strobe, 0);
        check("arst_din", io_din, 0);
        check("arst_addr", rd_addr, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_if.cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        exp_q.push_back(16'h0040);
        run_cmd(2'd0, 5'd0, 13'd0, 1, 16'h0040);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
